vid_timing_axis_gen: RTL and testbench

Parametrised video timing generator with an integrated AXI4-Stream video source. It produces hsync, vsync, video_on and pixel coordinates for any resolution and porch set, with programmable sync polarity. Visible pixels are taken from an external source or from a built-in test pattern, then buffered in an output FIFO that tolerates downstream backpressure. It replaces the fixed 640x480 timing and stream logic feeding the HDMI/VGA path in top.

---
 rtl/vid_timing_axis_gen_pkg.sv | 34 +++
 rtl/vid_timing_axis_gen_sync_fifo.sv | 63 ++++++
 rtl/vid_timing_axis_gen.sv | 167 ++++++++++++++++
 tb/tb_vid_timing_axis_gen.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/vid_timing_axis_gen_pkg.sv
// Shared types and default constants for the video timing generator.
//   pattern_e     : pixel source select encoding
//   DEF_*         : default 640x480@60 timing, used as parameter defaults
//   timing_total  : visible + porches + sync = line/frame total
//   bar_rgb       : per-channel on/off (r,g,b) for each of the 8 colour bars
package vid_timing_axis_gen_pkg;

    typedef enum logic [1:0] {
        PAT_EXT   = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_WHITE = 2'd3
    } pattern_e;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;

    function automatic int timing_total(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

    // Bar order white, yellow, cyan, green, magenta, red, blue, black:
    // r = ~idx[1], g = ~idx[2], b = ~idx[0].
    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        return {~idx[1], ~idx[2], ~idx[0]};
    endfunction

endpackage

// File: rtl/vid_timing_axis_gen_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
//   clk, rst_n       : clock, async active-low reset
//   wr_en, wr_data   : push (taken when not full, or when full with a pop)
//   rd_en, rd_data   : pop; rd_data shows the head entry, zero when empty
//   full, empty      : status
//   level            : occupancy 0..DEPTH
module vid_timing_axis_gen_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [W-1:0]               wr_data,
    input  logic                       rd_en,
    output logic [W-1:0]               rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_wr, do_rd;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign level = count;
    assign do_rd = rd_en && !empty;
    // When full, the write slot equals the head slot; it is only reused
    // when the head is being popped this cycle.
    assign do_wr = wr_en && (!full || do_rd);

    // Zero while empty so the output is defined without resetting storage.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vid_timing_axis_gen.sv
// Video timing generator with AXI4-Stream pixel output.
//   pixel_clk, reset_n      : clock, async active-low reset
//   enable                  : run counters (0 parks them at (0,0))
//   pattern_sel, ext_rgb    : pixel source and external pixel
//   clear_status            : clears sticky overflow
//   pixel_x/y, hsync, vsync, video_on, frame_start : decoded timing
//   tdata/tvalid/tready/tuser/tlast : AXIS video stream
//   overflow, fifo_level    : FIFO status
module vid_timing_axis_gen
    import vid_timing_axis_gen_pkg::*;
#(
    parameter int H_VISIBLE  = DEF_H_VISIBLE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_VISIBLE  = DEF_V_VISIBLE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit HSYNC_POL  = 1'b1,
    parameter bit VSYNC_POL  = 1'b1,
    parameter int RGB_W      = 12,
    parameter int CNT_W      = 10,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          pixel_clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic [1:0]                    pattern_sel,
    input  logic [RGB_W-1:0]              ext_rgb,
    input  logic                          clear_status,
    output logic [CNT_W-1:0]              pixel_x,
    output logic [CNT_W-1:0]              pixel_y,
    output logic                          hsync,
    output logic                          vsync,
    output logic                          video_on,
    output logic                          frame_start,
    output logic [RGB_W-1:0]              tdata,
    output logic                          tvalid,
    input  logic                          tready,
    output logic                          tuser,
    output logic                          tlast,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int H_MAX = timing_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
    localparam int V_MAX = timing_total(V_VISIBLE, V_FP, V_SYNC, V_BP);
    localparam int C_W   = RGB_W / 3;

    localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_MAX - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_MAX - 1);
    localparam logic [CNT_W-1:0] X_VIS    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] Y_VIS    = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] X_EOL    = CNT_W'(H_VISIBLE - 1);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FP + V_SYNC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef struct packed {
        logic             tuser;
        logic             tlast;
        logic [RGB_W-1:0] rgb;
    } beat_t;

    beat_t            push_beat, pop_beat;
    logic [RGB_W-1:0] pix_rgb;
    logic [2:0]       bar;
    int               bar_idx;
    logic             fifo_full, fifo_empty, pop, wr_en, set_ovf;
    logic             drop_state, drop_nxt;

    // ---------------- counters ----------------
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            pixel_x <= '0;
            pixel_y <= '0;
        end else if (!enable) begin
            pixel_x <= '0;
            pixel_y <= '0;
        end else if (pixel_x == X_LAST) begin
            pixel_x <= '0;
            pixel_y <= (pixel_y == Y_LAST) ? '0 : pixel_y + CNT_ONE;
        end else begin
            pixel_x <= pixel_x + CNT_ONE;
        end
    end

    // ---------------- timing decode ----------------
    always_comb begin
        hsync       = (pixel_x >= HS_START && pixel_x <= HS_END) ? HSYNC_POL : ~HSYNC_POL;
        vsync       = (pixel_y >= VS_START && pixel_y <= VS_END) ? VSYNC_POL : ~VSYNC_POL;
        video_on    = (pixel_x < X_VIS) && (pixel_y < Y_VIS) && enable;
        frame_start = video_on && (pixel_x == '0) && (pixel_y == '0);
    end

    // ---------------- pixel source ----------------
    always_comb begin
        bar_idx = (int'(pixel_x) * 8) / H_VISIBLE;
        bar     = bar_rgb(3'(bar_idx));
        case (pattern_e'(pattern_sel))
            PAT_BARS:  pix_rgb = {{C_W{bar[2]}}, {C_W{bar[1]}}, {C_W{bar[0]}}};
            PAT_CHECK: pix_rgb = (pixel_x[3] ^ pixel_y[3]) ? '1 : '0;
            PAT_WHITE: pix_rgb = '1;
            default:   pix_rgb = ext_rgb;
        endcase
    end

    assign push_beat = '{tuser: frame_start, tlast: (pixel_x == X_EOL), rgb: pix_rgb};

    // ---------------- push / drop control ----------------
    assign pop = tvalid && tready;

    // After a drop, discard until the next start-of-frame beat so the
    // stream never carries a partial frame.
    always_comb begin
        wr_en    = 1'b0;
        set_ovf  = 1'b0;
        drop_nxt = drop_state;
        if (video_on) begin
            if (drop_state && !push_beat.tuser) begin
                wr_en = 1'b0;
            end else if (!fifo_full || pop) begin
                wr_en    = 1'b1;
                drop_nxt = 1'b0;
            end else begin
                set_ovf  = 1'b1;
                drop_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_state <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            drop_state <= drop_nxt;
            if (set_ovf)           overflow <= 1'b1;
            else if (clear_status) overflow <= 1'b0;
        end
    end

    // ---------------- output FIFO ----------------
    vid_timing_axis_gen_sync_fifo #(
        .W     ($bits(beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (pixel_clk),
        .rst_n   (reset_n),
        .wr_en   (wr_en),
        .wr_data (push_beat),
        .rd_en   (pop),
        .rd_data (pop_beat),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign tvalid = !fifo_empty;
    assign tdata  = pop_beat.rgb;
    assign tuser  = pop_beat.tuser;
    assign tlast  = pop_beat.tlast;

endmodule

// File: tb/tb_vid_timing_axis_gen.sv
// Directed bench on a reduced 32x8 raster (H_MAX 48, V_MAX 14), active-low
// hsync, active-high vsync, 16-entry FIFO.
module tb_vid_timing_axis_gen;

    localparam int CNT_W = 6;
    localparam int RGB_W = 12;

    logic             pixel_clk_tb = 1'b0;
    logic             reset_n      = 1'b0;
    logic             enable       = 1'b0;
    logic [1:0]       pattern_sel  = 2'd1;
    logic [RGB_W-1:0] ext_rgb      = '0;
    logic             clear_status = 1'b0;
    logic             tready       = 1'b1;
    logic [CNT_W-1:0] pixel_x, pixel_y;
    logic             hsync, vsync, video_on, frame_start;
    logic [RGB_W-1:0] tdata;
    logic             tvalid, tuser, tlast, overflow;
    logic [4:0]       fifo_level;

    int n_asserts = 0;
    int n_fail    = 0;
    int beats = 0, tuser_cnt = 0, tlast_cnt = 0;
    int b0, u0, l0, b1;

    vid_timing_axis_gen #(
        .H_VISIBLE(32), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_VISIBLE(8),  .V_FP(2), .V_SYNC(2), .V_BP(2),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b1),
        .RGB_W(RGB_W), .CNT_W(CNT_W), .FIFO_DEPTH(16)
    ) dut (
        .pixel_clk(pixel_clk_tb), .reset_n(reset_n), .enable(enable),
        .pattern_sel(pattern_sel), .ext_rgb(ext_rgb), .clear_status(clear_status),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .hsync(hsync), .vsync(vsync),
        .video_on(video_on), .frame_start(frame_start), .tdata(tdata),
        .tvalid(tvalid), .tready(tready), .tuser(tuser), .tlast(tlast),
        .overflow(overflow), .fifo_level(fifo_level)
    );

    always #5 pixel_clk_tb = ~pixel_clk_tb;

    // Delivered-beat tallies
    always @(posedge pixel_clk_tb) begin
        if (tvalid && tready) begin
            beats     = beats + 1;
            tuser_cnt = tuser_cnt + int'(tuser);
            tlast_cnt = tlast_cnt + int'(tlast);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic goto(input int gx, input int gy);
        bit hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            if (int'(pixel_x) == gx && int'(pixel_y) == gy) hit = 1'b1;
            else @(negedge pixel_clk_tb);
        end
        chk($sformatf("reach_%0d_%0d", gx, gy), 32'(hit), 32'd1);
    endtask

    initial begin
        // reset state
        @(negedge pixel_clk_tb); @(negedge pixel_clk_tb);
        chk("rst_x", 32'(pixel_x), 0);
        chk("rst_y", 32'(pixel_y), 0);
        chk("rst_hsync", 32'(hsync), 1);
        chk("rst_vsync", 32'(vsync), 0);
        chk("rst_video_on", 32'(video_on), 0);
        chk("rst_frame_start", 32'(frame_start), 0);
        chk("rst_tvalid", 32'(tvalid), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_tdata", 32'(tdata), 0);
        chk("rst_tuser", 32'(tuser), 0);
        chk("rst_tlast", 32'(tlast), 0);
        chk("rst_overflow", 32'(overflow), 0);

        // frame 1: colour bars
        reset_n = 1'b1; enable = 1'b1; pattern_sel = 2'd1;
        #1;
        chk("f1_video_on", 32'(video_on), 1);
        chk("f1_frame_start", 32'(frame_start), 1);
        @(negedge pixel_clk_tb);
        chk("first_tvalid", 32'(tvalid), 1);
        chk("first_tdata", 32'(tdata), 32'hFFF);
        chk("first_tuser", 32'(tuser), 1);
        chk("first_level", 32'(fifo_level), 1);
        goto(5, 0);  chk("bar1", 32'(tdata), 32'hFF0); chk("bar1_tuser", 32'(tuser), 0);
        goto(29, 0); chk("bar7", 32'(tdata), 32'h000);
        goto(32, 0); chk("eol_tlast", 32'(tlast), 1); chk("hblank_video_on", 32'(video_on), 0);
        goto(35, 0); chk("hs_before", 32'(hsync), 1);
        goto(36, 0); chk("hs_first", 32'(hsync), 0);
        goto(43, 0); chk("hs_last", 32'(hsync), 0);
        goto(44, 0); chk("hs_after", 32'(hsync), 1);
        goto(47, 0); @(negedge pixel_clk_tb);
        chk("xwrap_x", 32'(pixel_x), 0); chk("xwrap_y", 32'(pixel_y), 1);
        goto(5, 8);  chk("vblank_video_on", 32'(video_on), 0);
        goto(0, 9);  chk("vs_before", 32'(vsync), 0);
        goto(0, 10); chk("vs_first", 32'(vsync), 1);
        goto(0, 11); chk("vs_last", 32'(vsync), 1);
        goto(0, 12); chk("vs_after", 32'(vsync), 0);
        goto(47, 13); @(negedge pixel_clk_tb);
        chk("ywrap_x", 32'(pixel_x), 0); chk("ywrap_y", 32'(pixel_y), 0);
        chk("ywrap_frame_start", 32'(frame_start), 1);
        chk("f1_beats", 32'(beats), 256);
        chk("f1_tuser", 32'(tuser_cnt), 1);
        chk("f1_tlast", 32'(tlast_cnt), 8);
        b0 = beats; u0 = tuser_cnt; l0 = tlast_cnt;

        // frame 2: checkerboard then solid white
        pattern_sel = 2'd2;
        @(negedge pixel_clk_tb);
        chk("chk_0_0", 32'(tdata), 32'h000); chk("f2_tuser", 32'(tuser), 1);
        goto(9, 0);  chk("chk_8_0", 32'(tdata), 32'hFFF);
        goto(0, 2);  pattern_sel = 2'd3;
        goto(0, 0);
        chk("f2_beats", 32'(beats - b0), 256);
        chk("f2_tuser", 32'(tuser_cnt - u0), 1);
        chk("f2_tlast", 32'(tlast_cnt - l0), 8);

        // frame 3: backpressure on line 2
        goto(0, 2);  tready = 1'b0; b1 = beats;
        goto(16, 2); chk("bp_full_level", 32'(fifo_level), 16); chk("bp_ovf_pre", 32'(overflow), 0);
        goto(20, 2);
        chk("bp_level", 32'(fifo_level), 16);
        chk("bp_overflow", 32'(overflow), 1);
        chk("bp_tvalid", 32'(tvalid), 1);
        chk("bp_hold_tdata", 32'(tdata), 32'hFFF);
        chk("bp_hold_tuser", 32'(tuser), 0);
        goto(40, 2); tready = 1'b1;
        goto(0, 5);
        chk("drop_level", 32'(fifo_level), 0);
        chk("drop_tvalid", 32'(tvalid), 0);
        chk("drop_overflow", 32'(overflow), 1);
        goto(0, 0);
        chk("bp_delivered", 32'(beats - b1), 16);
        chk("resync_level", 32'(fifo_level), 0);
        @(negedge pixel_clk_tb);
        chk("resync_tvalid", 32'(tvalid), 1);
        chk("resync_tuser", 32'(tuser), 1);
        clear_status = 1'b1;
        @(negedge pixel_clk_tb);
        clear_status = 1'b0;
        chk("clear_overflow", 32'(overflow), 0);

        // enable low for 1000 cycles
        goto(4, 3);  tready = 1'b0;
        goto(10, 3); chk("en_level_pre", 32'(fifo_level), 7);
        enable = 1'b0; tready = 1'b1;
        #1 chk("en_off_video_on", 32'(video_on), 0);
        @(negedge pixel_clk_tb);
        chk("en_off_x", 32'(pixel_x), 0); chk("en_off_y", 32'(pixel_y), 0);
        chk("en_off_level", 32'(fifo_level), 6);
        repeat (999) @(negedge pixel_clk_tb);
        chk("en_idle_x", 32'(pixel_x), 0); chk("en_idle_y", 32'(pixel_y), 0);
        chk("en_idle_level", 32'(fifo_level), 0); chk("en_idle_tvalid", 32'(tvalid), 0);
        chk("en_idle_video_on", 32'(video_on), 0);
        chk("en_idle_hsync", 32'(hsync), 1); chk("en_idle_vsync", 32'(vsync), 0);
        enable = 1'b1;
        #1 chk("en_on_frame_start", 32'(frame_start), 1);
        @(negedge pixel_clk_tb);
        chk("en_on_tuser", 32'(tuser), 1); chk("en_on_x", 32'(pixel_x), 1);

        // reset mid-line
        goto(15, 5); tready = 1'b0;
        goto(20, 5); chk("mid_level_pre", 32'(fifo_level), 6);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_x", 32'(pixel_x), 0); chk("mid_rst_y", 32'(pixel_y), 0);
        chk("mid_rst_tvalid", 32'(tvalid), 0); chk("mid_rst_level", 32'(fifo_level), 0);
        chk("mid_rst_tdata", 32'(tdata), 0);
        @(negedge pixel_clk_tb);
        reset_n = 1'b1; tready = 1'b1;
        #1 chk("mid_rel_frame_start", 32'(frame_start), 1);
        @(negedge pixel_clk_tb);
        chk("mid_rel_tvalid", 32'(tvalid), 1);
        chk("mid_rel_tuser", 32'(tuser), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
